// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx
//   Audio stage that sits directly after the Tecmo core. Signed stereo sample
//   pairs are buffered in a small FIFO and sent out as I2S on the scaler audio
//   pins. MCLK (12.288 MHz) comes from a fractional accumulator running on the
//   74.25 MHz bridge clock. An internal SCLK of MCLK/4 is used but not output.
//   LRCK runs at 48 kHz, with 64 SCLK periods per frame.
//
// Ports
//   clock_i         bridge clock (clk_74a); all logic is on the rising edge
//   reset_i         synchronous, active-high reset
//   sample_valid_i  a stereo pair is offered this cycle
//   sample_ready_o  FIFO can take a pair; a push happens on valid & ready
//   sample_l_i      left sample, two's complement
//   sample_r_i      right sample, two's complement
//   fifo_level_o    number of occupied FIFO entries
//   underrun_o      sticky flag, set when a frame starts with the FIFO empty
//   audio_mclk_o    master clock to the DAC
//   audio_lrck_o    word select: 0 = left slot, 1 = right slot
//   audio_dac_o     serial data; changes on SCLK falling events
//
// Build option
//   AUDIO_I2S_MONO_MIX_EN  if defined, each loaded pair is replaced by
//                          (L+R)>>>1 on both channels.

module audio_i2s_tx #(
  parameter int unsigned ACC_INC    = 245760,
  parameter int unsigned ACC_MOD    = 742500,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SAMPLE_W   = 16,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                sample_valid_i,
  output logic                sample_ready_o,
  input  logic [SAMPLE_W-1:0] sample_l_i,
  input  logic [SAMPLE_W-1:0] sample_r_i,
  output logic [LVL_W-1:0]    fifo_level_o,
  output logic                underrun_o,
  output logic                audio_mclk_o,
  output logic                audio_lrck_o,
  output logic                audio_dac_o
);

  localparam int unsigned ACC_W = 22;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned IDX_W = $clog2(SAMPLE_W);
  localparam logic [ACC_W:0]   INC_C   = ACC_INC[ACC_W:0];
  localparam logic [ACC_W:0]   MOD_C   = ACC_MOD[ACC_W:0];
  localparam logic [LVL_W-1:0] DEPTH_C = FIFO_DEPTH[LVL_W-1:0];

  // State registers
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                mclk_q;
  logic [1:0]          sclk_div_q;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic                lrck_q;
  logic                dac_q;
  logic                underrun_q;
  logic                ready_q;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [SAMPLE_W-1:0] held_l_q, held_r_q;
  logic [2*SAMPLE_W-1:0] mem_q [FIFO_DEPTH];

  // Clock generation
  logic [ACC_W:0] acc_sum;
  logic           acc_wrap;
  logic           mclk_rise;
  logic           sclk_fall;

  assign acc_sum   = {1'b0, acc_q} + INC_C;
  assign acc_wrap  = (acc_sum >= MOD_C);
  assign acc_d     = acc_wrap ? ACC_W'(acc_sum - MOD_C) : acc_sum[ACC_W-1:0];
  // MCLK toggles on every wrap, so only wraps that take it 0->1 are rising edges.
  assign mclk_rise = acc_wrap & ~mclk_q;
  // SCLK falls once every four MCLK rises, when the divider rolls over 3->0.
  assign sclk_fall = mclk_rise & (sclk_div_q == 2'd3);
  assign bit_cnt_d = sclk_fall ? bit_cnt_q + 6'd1 : bit_cnt_q;

  // FIFO control
  logic frame_start;
  logic push;
  logic pop;

  assign frame_start = sclk_fall & (bit_cnt_q == 6'd63);
  assign pop         = frame_start & (level_q != '0);
  assign push        = sample_valid_i & ready_q & (level_q != DEPTH_C);

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pair loaded into the held registers at frame start
  logic [2*SAMPLE_W-1:0] pop_pair;
  logic [SAMPLE_W-1:0]   load_l, load_r;

  assign pop_pair = mem_q[rd_ptr_q];

`ifdef AUDIO_I2S_MONO_MIX_EN
  // Use a sum one bit wider than the samples so it cannot overflow.
  // Dropping the LSB is an arithmetic shift, which truncates toward -inf.
  logic [SAMPLE_W:0] mix_sum;
  assign mix_sum = {pop_pair[2*SAMPLE_W-1], pop_pair[2*SAMPLE_W-1:SAMPLE_W]}
                 + {pop_pair[SAMPLE_W-1], pop_pair[SAMPLE_W-1:0]};
  assign load_l  = mix_sum[SAMPLE_W:1];
  assign load_r  = mix_sum[SAMPLE_W:1];
`else
  assign load_l  = pop_pair[2*SAMPLE_W-1:SAMPLE_W];
  assign load_r  = pop_pair[SAMPLE_W-1:0];
`endif

  // Serial bit selection
  // Slot position 0 stays zero. This places the MSB one SCLK after the LRCK
  // edge, as I2S requires. Positions above SAMPLE_W pad the slot with zeros.
  logic [4:0]          slot_pos;
  logic [SAMPLE_W-1:0] slot_sample;
  logic [IDX_W-1:0]    slot_idx;
  logic                dac_bit;

  assign slot_pos    = bit_cnt_d[4:0];
  assign slot_sample = bit_cnt_d[5] ? held_r_q : held_l_q;
  assign slot_idx    = IDX_W'(SAMPLE_W - 32'(slot_pos));

  always_comb begin
    dac_bit = 1'b0;
    if ((slot_pos != 5'd0) && (32'(slot_pos) <= SAMPLE_W)) begin
      dac_bit = slot_sample[slot_idx];
    end
  end

  // FIFO storage. Reset does not clear it; reset empties the FIFO by
  // clearing the pointers and the level.
  always_ff @(posedge clock_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {sample_l_i, sample_r_i};
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      acc_q      <= '0;
      mclk_q     <= 1'b0;
      sclk_div_q <= 2'd0;
      bit_cnt_q  <= 6'd0;
      lrck_q     <= 1'b0;
      dac_q      <= 1'b0;
      underrun_q <= 1'b0;
      ready_q    <= 1'b0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      held_l_q   <= '0;
      held_r_q   <= '0;
    end else begin
      acc_q  <= acc_d;
      mclk_q <= mclk_q ^ acc_wrap;
      if (mclk_rise) begin
        sclk_div_q <= sclk_div_q + 2'd1;
      end
      if (sclk_fall) begin
        bit_cnt_q <= bit_cnt_d;
        lrck_q    <= bit_cnt_d[5];
        dac_q     <= dac_bit;
      end
      if (pop) begin
        held_l_q <= load_l;
        held_r_q <= load_r;
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      // If the FIFO is empty at frame start, the previous pair plays again.
      if (frame_start && (level_q == '0)) begin
        underrun_q <= 1'b1;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      level_q <= level_d;
      ready_q <= (level_d < DEPTH_C);
    end
  end

  assign sample_ready_o = ready_q;
  assign fifo_level_o   = level_q;
  assign underrun_o     = underrun_q;
  assign audio_mclk_o   = mclk_q;
  assign audio_lrck_o   = lrck_q;
  assign audio_dac_o    = dac_q;

endmodule
